// File: rtl/clk_en_sched.sv
// clk_en_sched -- multi-channel clock-enable scheduler.
//
// Generates, per channel, a one-cycle tick strobe every Deff cycles and a
// square-wave enable with period Deff, all derived from the single system
// clock. Deff = max(div, 2). Channel divisors/enables are reconfigured
// through a one-deep valid/ready slot; a pending update lands on the
// target's terminal count (or at once when imm is set or the channel is
// disabled). sync_req zeroes every enabled counter to realign phases.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   cfg_valid/ready  config handshake (ready = slot empty)
//   cfg_ch           target channel (out-of-range targets are dropped)
//   cfg_div, cfg_en  new divisor and enable
//   cfg_imm          apply on the next edge instead of at terminal count
//   sync_req         one-cycle pulse: restart all enabled channel phases
//   tick[N_CH]       one-cycle strobe in the terminal cycle of each period
//   clk_out[N_CH]    high for the upper (shorter-or-equal) part of the period
//   busy             an update is pending
module clk_en_sched #(
  parameter int              N_CH    = 4,
  parameter int              W       = 16,
  parameter int              DEF_DIV = 8,
  parameter logic [N_CH-1:0] EN_RST  = '1,
  localparam int             CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_div,
  input  logic            cfg_en,
  input  logic            cfg_imm,
  input  logic            sync_req,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] clk_out,
  output logic            busy
);

  // Divisors 0 and 1 behave as 2.
  function automatic logic [W-1:0] deff_f(input logic [W-1:0] d);
    return (d < W'(2)) ? W'(2) : d;
  endfunction

  // H = (Deff+1)>>1, computed one bit wider so Deff = all-ones cannot wrap.
  function automatic logic [W-1:0] half_f(input logic [W-1:0] de);
    logic [W:0] s;
    s = {1'b0, de} + (W+1)'(1);
    return s[W:1];
  endfunction

  logic [N_CH-1:0][W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][W-1:0] div_q, div_d;
  logic [N_CH-1:0]        en_q, en_d;
  logic [N_CH-1:0]        tick_q, tick_d;
  logic [N_CH-1:0]        clk_out_q, clk_out_d;
  logic [N_CH-1:0]        term_v;
  logic [N_CH-1:0]        apply_v;

  // Pending config slot.
  logic            pend_q, pend_d;
  logic [CH_W-1:0] pch_q;
  logic [W-1:0]    pdiv_q;
  logic            pen_q;
  logic            pimm_q;
  logic            ch_ok;

  assign ch_ok = int'(pch_q) < N_CH;

  always_comb begin
    term_v = '0;
    for (int i = 0; i < N_CH; i++) begin
      term_v[i] = en_q[i] && (cnt_q[i] == deff_f(div_q[i]) - W'(1));
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    en_d      = en_q;
    tick_d    = '0;
    clk_out_d = '0;
    apply_v   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pend_q && (pch_q == CH_W'(i)) && (!en_q[i] || term_v[i] || pimm_q)) begin
        // Apply takes priority over sync and wrap; both would also zero cnt.
        apply_v[i] = 1'b1;
        div_d[i]   = pdiv_q;
        en_d[i]    = pen_q;
        cnt_d[i]   = '0;
      end else if (!en_q[i] || term_v[i] || sync_req) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + W'(1);
      end
      // Outputs are registered copies decoded from the next counter state,
      // so they always describe the cycle cnt_q is in.
      tick_d[i]    = en_d[i] && (cnt_d[i] == deff_f(div_d[i]) - W'(1));
      clk_out_d[i] = en_d[i] && (cnt_d[i] >= half_f(deff_f(div_d[i])));
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (pend_q) begin
      // Out-of-range targets drop out on the edge after capture.
      if ((|apply_v) || !ch_ok) pend_d = 1'b0;
    end else if (cfg_valid) begin
      pend_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= {N_CH{W'(DEF_DIV)}};
      en_q      <= EN_RST;
      tick_q    <= '0;
      clk_out_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      en_q      <= en_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      pend_q    <= pend_d;
    end
  end

  // NOTE: the slot payload is reset too, so no partial config can ever be
  // observed after reset even though pend_q alone gates its use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pch_q  <= '0;
      pdiv_q <= '0;
      pen_q  <= 1'b0;
      pimm_q <= 1'b0;
    end else if (cfg_valid && !pend_q) begin
      pch_q  <= cfg_ch;
      pdiv_q <= cfg_div;
      pen_q  <= cfg_en;
      pimm_q <= cfg_imm;
    end
  end

  assign cfg_ready = ~pend_q;
  assign busy      = pend_q;
  assign tick      = tick_q;
  assign clk_out   = clk_out_q;

endmodule
